// File: rtl/sprite_dma_if.sv
// rtl/sprite_dma_if.sv - CPU-side and system-bus-side signal bundle for sprite_dma
interface sprite_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic        busy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic [7:0]  bus_rdata;

  modport master (
    input  cpu_addr, cpu_odata, cpu_rw, bus_rdata,
    output cpu_rdy, busy, bus_addr, bus_wdata, bus_rw
  );

  modport slave (
    output cpu_addr, cpu_odata, cpu_rw, bus_rdata,
    input  cpu_rdy, busy, bus_addr, bus_wdata, bus_rw
  );
endinterface

// File: rtl/sprite_dma.sv
// rtl/sprite_dma.sv - page-to-register sprite DMA that halts the CPU and masters the system bus
module sprite_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cyc_en,
  sprite_dma_if.master io
);
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    if (cyc_en) begin
      // par_q high means the current bus cycle is odd, so the next one is even
      par_d = ~par_q;
      case (state_q)
        S_IDLE: begin
          if (!io.cpu_rw && io.cpu_addr == TRIG_ADDR) begin
            page_d  = io.cpu_odata;
            idx_d   = 8'h00;
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          // the CPU only honours rdy on a read cycle, so writes keep us waiting
          if (io.cpu_rw) state_d = par_q ? S_READ : S_ALIGN;
        end
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          data_d  = io.bus_rdata;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign io.cpu_rdy = (state_q == S_IDLE);
  assign io.busy    = (state_q != S_IDLE);

  always_comb begin
    io.bus_addr  = io.cpu_addr;
    io.bus_wdata = io.cpu_odata;
    io.bus_rw    = io.cpu_rw;
    if (state_q == S_READ) begin
      io.bus_addr  = {page_q, idx_q};
      io.bus_wdata = data_q;
      io.bus_rw    = 1'b1;
    end else if (state_q == S_WRITE) begin
      io.bus_addr  = DEST_ADDR;
      io.bus_wdata = data_q;
      io.bus_rw    = 1'b0;
    end
  end
endmodule

// File: tb/tb_sprite_dma.sv
// tb/tb_sprite_dma.sv - randomized bench for sprite_dma against an expected bus-cycle list
module tb_sprite_dma;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cyc_en = 1'b0;
  always #5 clk = ~clk;

  sprite_dma_if ifc();
  sprite_dma dut (.clk(clk), .reset(reset), .cyc_en(cyc_en), .io(ifc.master));

  logic [7:0] mem [0:65535];
  assign ifc.bus_rdata = mem[ifc.bus_addr];

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int gap = 1;

  logic        o_rdy, o_busy, o_rw;
  logic [15:0] o_addr;
  logic [7:0]  o_wdata;

  typedef struct {
    bit          pass;
    logic [15:0] a;
    bit          rw;
    logic [7:0]  wd;
    int          idx;
  } ent_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One CPU bus cycle: drive, idle some clocks, then sample just before the cyc_en edge
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    int g;
    ifc.cpu_addr = a;
    ifc.cpu_odata = d;
    ifc.cpu_rw = rw;
    cyc_en = 1'b0;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (g) @(negedge clk);
    cyc_en = 1'b1;
    #1;
    o_rdy = ifc.cpu_rdy;
    o_busy = ifc.busy;
    o_addr = ifc.bus_addr;
    o_rw = ifc.bus_rw;
    o_wdata = ifc.bus_wdata;
    @(posedge clk);
    @(negedge clk);
    cyc_en = 1'b0;
    cyc_cnt++;
  endtask

  task automatic idle_cycle(input string tag, input logic [15:0] a, input logic [7:0] d, input logic rw);
    cpu_cycle(a, d, rw);
    check({tag, "_rdy"}, o_rdy, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_addr"}, o_addr, a);
    check({tag, "_rw"}, o_rw, rw);
    check({tag, "_wdata"}, o_wdata, d);
  endtask

  task automatic run_transfer(input logic [7:0] page, input bit n1_even, input int extra, input int abort_idx);
    ent_t exp_q[$];
    ent_t e;
    int h, lo, abort_at;
    bit seen, align;
    logic [15:0] stall, a;
    logic [7:0] d;
    logic rw;
    if ((((cyc_cnt + 1) % 2) == 0) != n1_even)
      idle_cycle("pad", 16'h8000 | 16'($urandom_range(0, 16'h7fff)), 8'($urandom), 1'b1);
    idle_cycle("trig", 16'h4014, page, 1'b0);
    h = cyc_cnt + extra;
    align = ((h + 1) % 2) != 0;
    for (int k = 0; k < extra + 1 + int'(align); k++) begin
      e = '{pass: 1'b1, a: 16'h0, rw: 1'b1, wd: 8'h0, idx: -1};
      exp_q.push_back(e);
    end
    abort_at = -1;
    for (int i = 0; i < 256; i++) begin
      e = '{pass: 1'b0, a: {page, 8'(i)}, rw: 1'b1, wd: 8'h0, idx: i};
      exp_q.push_back(e);
      if (i == abort_idx) abort_at = exp_q.size();
      e = '{pass: 1'b0, a: 16'h2004, rw: 1'b0, wd: mem[{page, 8'(i)}], idx: i};
      exp_q.push_back(e);
    end
    stall = 16'h8000 | 16'($urandom_range(1, 16'h7fff));
    seen = 1'b0;
    lo = 0;
    for (int k = 0; k < 700 && !seen; k++) begin
      if (k < extra) begin
        a = (k == 0) ? 16'h4014 : 16'($urandom);
        d = 8'($urandom);
        rw = 1'b0;
      end else begin
        a = stall;
        d = 8'($urandom);
        rw = 1'b1;
      end
      if (k == abort_at) begin
        ifc.cpu_addr = a;
        ifc.cpu_odata = d;
        ifc.cpu_rw = rw;
        cyc_en = 1'b0;
        #1;
        check("abort_in_write", ifc.bus_addr, 16'h2004);
        reset = 1'b0;
        #1;
        check("abort_rdy", ifc.cpu_rdy, 1);
        check("abort_busy", ifc.busy, 0);
        check("abort_addr", ifc.bus_addr, a);
        check("abort_rw", ifc.bus_rw, rw);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc_cnt = 0;
        return;
      end
      cpu_cycle(a, d, rw);
      if (!o_rdy) lo++;
      if (o_rdy) begin
        seen = 1'b1;
        check("post_busy", o_busy, 0);
        check("post_addr", o_addr, a);
        check("post_rw", o_rw, rw);
      end else if (k < exp_q.size()) begin
        e = exp_q[k];
        check("halt_busy", o_busy, 1);
        if (e.pass) begin
          check("halt_pass_addr", o_addr, a);
          check("halt_pass_rw", o_rw, rw);
        end else begin
          check("dma_addr", o_addr, e.a);
          check("dma_rw", o_rw, e.rw);
          if (!e.rw) check("dma_wdata", o_wdata, e.wd);
        end
      end
    end
    check("halt_seen", seen, 1);
    check("halt_len", lo, exp_q.size());
  endtask

  initial begin
    logic [15:0] a;
    ifc.cpu_addr = 16'h0000;
    ifc.cpu_odata = 8'h00;
    ifc.cpu_rw = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdy", ifc.cpu_rdy, 1);
    check("rst_busy", ifc.busy, 0);
    check("rst_addr", ifc.bus_addr, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    cyc_cnt = 0;

    gap = 1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4000;
      idle_cycle("pass", a, 8'($urandom), 1'($urandom));
    end

    gap = -1;
    run_transfer(8'h02, 1'b0, 0, -1);
    run_transfer(8'h02, 1'b1, 0, -1);

    idle_cycle("ign4015", 16'h4015, 8'h07, 1'b0);
    idle_cycle("ign4013", 16'h4013, 8'h07, 1'b0);
    idle_cycle("ignrd4014", 16'h4014, 8'h07, 1'b1);
    idle_cycle("ignafter", 16'h1234, 8'h00, 1'b1);

    run_transfer(8'hFF, 1'($urandom), 2, -1);

    run_transfer(8'($urandom), 1'($urandom), 0, 8'h63);
    for (int i = 0; i < 3; i++) idle_cycle("aftrst", 16'h8000 | 16'(i), 8'h00, 1'b1);
    run_transfer(8'h03, 1'($urandom), 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_dma.md
# sprite_dma

Bus-mastering DMA controller for the cpu6502 system bus. A CPU write of page number P to a trigger register halts the CPU through `cpu_rdy`, then takes the bus and copies 256 bytes from $PP00–$PPFF to a fixed destination register, one read cycle plus one write cycle per byte. The block sits between the cpu6502 bus pins and memory/peripherals. Outside a transfer it passes CPU bus signals straight through.

## Interface
- `TRIG_ADDR`, 16'h4014, CPU write address that starts a transfer.
- `DEST_ADDR`, 16'h2004, destination address for every DMA write.

- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `cyc_en`  input  1  one-`clk` pulse marking the end of each CPU bus cycle (data capture point).
- `cpu_addr`  input  16  CPU address.
- `cpu_odata`  input  8  CPU write data.
- `cpu_rw`  input  1  CPU read/write; 1 = read.
- `cpu_rdy`  output  1  0 halts the CPU.
- `busy`  output  1  high from trigger detection until the last DMA write completes.
- `bus_addr`  output  16  system bus address.
- `bus_wdata`  output  8  system bus write data.
- `bus_rw`  output  1  system bus read/write; 1 = read.
- `bus_rdata`  input  8  system bus read data.

## Operation
- State machine: IDLE, HALT, ALIGN, READ, WRITE. All transitions happen only on `cyc_en`.
- **IDLE**
  - `cpu_rdy`=1 and `busy`=0.
  - The bus mux passes `cpu_addr`, `cpu_odata` and `cpu_rw` through.
  - On `cyc_en` with `cpu_rw`=0 and `cpu_addr`==TRIG_ADDR: latch `page`←`cpu_odata`, set `idx`←0, go to HALT.
  - Reads of TRIG_ADDR and writes to any other address do nothing.
- **HALT**
  - `cpu_rdy`=0 and `busy`=1. The bus still passes the CPU through.
  - On `cyc_en`, if `cpu_rw`=0, stay in HALT; the CPU only stops on a read cycle.
  - Otherwise, go to READ if the parity bit is 1 (the next cycle is even), or to ALIGN if it is 0.
- **ALIGN**
  - One dummy cycle with `cpu_rdy`=0. Bus is passthrough; the CPU's stalled read is harmless.
  - Go to READ.
- **READ**
  - Drive `bus_addr`={page,idx} and `bus_rw`=1.
  - On `cyc_en`: `data`←`bus_rdata`, go to WRITE.
- **WRITE**
  - Drive `bus_addr`=DEST_ADDR, `bus_wdata`=`data`, `bus_rw`=0.
  - On `cyc_en` with `idx`==8'hFF: go to IDLE.
  - On `cyc_en` otherwise: `idx`←`idx`+1, go to READ.
- Parity bit: toggles on every `cyc_en`; reset value 0, so the first cycle after reset is even. READ cycles always land on even cycles.
- `idx` is 8 bits and never carries into `page`. A transfer from page $FF reads $FF00–$FFFF.
- `cpu_rdy`, `busy` and the bus mux select are combinational decodes of registered state, so they are glitch-free within a cycle.

## Timing
- Reset (asynchronous, active-low) forces:
  - state=IDLE, `page`=0, `idx`=0, `data`=0, parity=0;
  - `cpu_rdy`=1, `busy`=0, bus in passthrough.
- Reset mid-transfer aborts immediately; no further DMA bus cycles occur.
- Trigger write completes in cycle N. `cpu_rdy` falls at the start of cycle N+1.
- Halt length, counted with `cpu_rdy` low, when cycle N+1 is a read:
  - 513 cycles if N+1 is odd (HALT + 512);
  - 514 cycles if N+1 is even (HALT + ALIGN + 512).
- Each extra write cycle the CPU is in at N+1 adds one HALT cycle.
- `cpu_rdy` returns high in the cycle after the final WRITE (idx $FF).
- Read-to-write latency per byte is one cycle; `bus_rdata` is captured at the READ cycle's `cyc_en`.
- Trigger writes while not in IDLE are ignored; the CPU is halted anyway.
- `clk` edges without `cyc_en` change no state.

## Test plan
- Reset release with `cyc_en` every 2 `clk` → `cpu_rdy`=1, `busy`=0, and `bus_addr`/`bus_rw`/`bus_wdata` track the CPU signals exactly.
- CPU writes $02 to $4014 with N+1 odd, memory $0200+i = i^$5A → `cpu_rdy` low for exactly 513 cycles. Bus shows 256 read/write pairs: read $0200+i, then write $2004 with i^$5A, i = 0..255 in order.
- Same trigger with N+1 even → one ALIGN passthrough cycle, and `cpu_rdy` low for exactly 514 cycles.
- Writes to $4015 and $4013, and a read of $4014 → no state change, `cpu_rdy` stays 1.
- Page $FF transfer → last read is $FFFF, followed by a write to $2004, then IDLE; no access to $0000.
- Reset asserted during the WRITE of idx $63 → `cpu_rdy`=1 and passthrough immediately. A new trigger with page $03 then starts at $0300.
